progmem_ctrl: RTL

Sequencer and arbiter in front of the 16x16 program memory (`progmem`). It shares the single memory port between two users: the CPU instruction fetch path, and a host byte-stream loader that rewrites the whole memory, then reads it back and checks it. While a load is in progress the CPU is held in halt.

---
 rtl/progmem_ctrl_if.sv | 25 ++
 rtl/progmem_ctrl.sv | 139 +++++++++++++
 2 files changed

// File: rtl/progmem_ctrl_if.sv
// Program-memory port bundle between the controller (master)
// and the single-port progmem (slave).
interface progmem_ctrl_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 16
);
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_din;
  logic              mem_write_en;
  logic [DATA_W-1:0] mem_dout;

  modport master (
    output mem_addr,
    output mem_din,
    output mem_write_en,
    input  mem_dout
  );

  modport slave (
    input  mem_addr,
    input  mem_din,
    input  mem_write_en,
    output mem_dout
  );
endinterface

// File: rtl/progmem_ctrl.sv
// Arbitrates progmem between CPU fetch and a host byte-stream
// loader that rewrites, reads back and checksums the memory.
module progmem_ctrl #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic [DATA_W-1:0] fetch_data,
  output logic              fetch_valid,
  output logic              cpu_halt,
  input  logic              ld_start,
  input  logic [7:0]        ld_byte,
  input  logic              ld_valid,
  output logic              ld_ready,
  output logic              ld_done,
  output logic              ld_ok,
  output logic [DATA_W-1:0] ld_csum,
  progmem_ctrl_if.master    mem
);

  typedef enum logic [2:0] {
    RUN, LOAD_HI, LOAD_LO, WRITE, VERIFY, VDRAIN, DONE
  } state_t;

  localparam logic [ADDR_W-1:0] LAST = '1;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [DATA_W-1:0] word_q, word_d;
  logic [DATA_W-1:0] wx_q, wx_d;
  logic [DATA_W-1:0] rx_q, rx_d;
  logic              rd_vld_q, rd_vld_d;
  logic              fv_q, fv_d;
  logic              ok_q, ok_d;
  logic [DATA_W-1:0] csum_q, csum_d;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= RUN;
      cnt_q    <= '0;
      word_q   <= '0;
      wx_q     <= '0;
      rx_q     <= '0;
      rd_vld_q <= 1'b0;
      fv_q     <= 1'b0;
      ok_q     <= 1'b0;
      csum_q   <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      word_q   <= word_d;
      wx_q     <= wx_d;
      rx_q     <= rx_d;
      rd_vld_q <= rd_vld_d;
      fv_q     <= fv_d;
      ok_q     <= ok_d;
      csum_q   <= csum_d;
    end
  end

  always_comb begin
    state_d          = state_q;
    cnt_d            = cnt_q;
    word_d           = word_q;
    wx_d             = wx_q;
    // readback arrives one cycle after its address was issued
    rx_d             = rd_vld_q ? (rx_q ^ mem.mem_dout) : rx_q;
    rd_vld_d         = 1'b0;
    fv_d             = 1'b0;
    ok_d             = ok_q;
    csum_d           = csum_q;
    mem.mem_addr     = '0;
    mem.mem_din      = '0;
    mem.mem_write_en = 1'b0;
    ld_ready         = 1'b0;
    ld_done          = 1'b0;
    unique case (state_q)
      RUN: begin
        mem.mem_addr = fetch_addr;
        if (ld_start) begin
          state_d = LOAD_HI;
          cnt_d   = '0;
          wx_d    = '0;
          rx_d    = '0;
        end else begin
          fv_d = fetch_req;
        end
      end
      LOAD_HI: begin
        ld_ready = 1'b1;
        if (ld_valid) begin
          word_d[15:8] = ld_byte;
          state_d      = LOAD_LO;
        end
      end
      LOAD_LO: begin
        ld_ready = 1'b1;
        if (ld_valid) begin
          word_d[7:0] = ld_byte;
          state_d     = WRITE;
        end
      end
      WRITE: begin
        mem.mem_write_en = 1'b1;
        mem.mem_addr     = cnt_q;
        mem.mem_din      = word_q;
        wx_d             = wx_q ^ word_q;
        cnt_d            = cnt_q + 1'b1;
        state_d          = (cnt_q == LAST) ? VERIFY : LOAD_HI;
      end
      VERIFY: begin
        mem.mem_addr = cnt_q;
        cnt_d        = cnt_q + 1'b1;
        rd_vld_d     = 1'b1;
        if (cnt_q == LAST) state_d = VDRAIN;
      end
      VDRAIN: begin
        state_d = DONE;
      end
      DONE: begin
        ld_done = 1'b1;
        csum_d  = wx_q;
        ok_d    = (rx_q == wx_q);
        state_d = RUN;
      end
      default: state_d = RUN;
    endcase
  end

  assign fetch_valid = fv_q;
  assign fetch_data  = fv_q ? mem.mem_dout : '0;
  assign cpu_halt    = (state_q != RUN);
  assign ld_ok       = ok_q;
  assign ld_csum     = csum_q;

endmodule
